hcsr04_sensor_model: RTL and testbench

//  Synthesizable HC-SR04 responder: the sensor side of the trigger/echo protocol.

---
 rtl/hcsr04_sensor_model.sv | 134 +++++++++++++
 tb/tb_hcsr04_sensor_model.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hcsr04_sensor_model.sv
// HC-SR04 sensor-side responder: validates trigger width, waits the burst time,
// then emits an echo pulse of programmed width followed by a holdoff dead time.
module hcsr04_sensor_model #(
  parameter int unsigned T_CLK       = 10,
  parameter int unsigned TRIG_MIN_US = 10,
  parameter int unsigned T_BURST_US  = 200,
  parameter int unsigned ECHO_MAX_US = 38000,
  parameter int unsigned HOLDOFF_US  = 10000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_trigger,
  input  logic [15:0] i_echo_us,
  output logic        o_echo,
  output logic        o_busy,
  output logic        o_trig_err
);

  localparam int unsigned CYC_US       = 1000 / T_CLK;
  localparam int unsigned TRIG_CYC     = TRIG_MIN_US * CYC_US;
  localparam int unsigned BURST_CYC    = T_BURST_US * CYC_US;
  localparam int unsigned HOLD_CYC     = HOLDOFF_US * CYC_US;
  localparam int unsigned ECHO_MAX_CYC = ECHO_MAX_US * CYC_US;
  localparam int unsigned MAX_BH       = (BURST_CYC > HOLD_CYC) ? BURST_CYC : HOLD_CYC;
  localparam int unsigned MAX_CYC      = (ECHO_MAX_CYC > MAX_BH) ? ECHO_MAX_CYC : MAX_BH;
  localparam int unsigned CNT_W        = $clog2(MAX_CYC + 1);
  localparam int unsigned TRIG_W       = $clog2(TRIG_CYC + 1);

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StBurst,
    StEcho,
    StHoldoff
  } state_e;

  state_e            r_state;
  logic [TRIG_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0]  r_cnt;
  logic [15:0]       r_w;
  logic              r_echo;
  logic              r_busy;
  logic              r_trig_err;

  logic [15:0]       w_w_clamped;
  logic [CNT_W-1:0]  w_echo_last;

  // Zero means "no object", so it maps to the full no-echo width like an overrange value.
  always_comb begin
    w_w_clamped = i_echo_us;
    if (i_echo_us == 16'd0 || i_echo_us > 16'(ECHO_MAX_US)) begin
      w_w_clamped = 16'(ECHO_MAX_US);
    end
    w_echo_last = CNT_W'(32'(r_w) * CYC_US - 32'd1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_hi_cnt   <= '0;
      r_cnt      <= '0;
      r_w        <= '0;
      r_echo     <= 1'b0;
      r_busy     <= 1'b0;
      r_trig_err <= 1'b0;
    end else begin
      r_trig_err <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_trigger) begin
            r_state  <= StTrig;
            r_hi_cnt <= TRIG_W'(1);
            r_busy   <= 1'b1;
          end
        end
        StTrig: begin
          if (i_trigger) begin
            if (r_hi_cnt < TRIG_W'(TRIG_CYC)) begin
              r_hi_cnt <= r_hi_cnt + TRIG_W'(1);
            end
          end else if (r_hi_cnt >= TRIG_W'(TRIG_CYC)) begin
            r_state  <= StBurst;
            r_w      <= w_w_clamped;
            r_cnt    <= '0;
            r_hi_cnt <= '0;
          end else begin
            r_state    <= StIdle;
            r_busy     <= 1'b0;
            r_trig_err <= 1'b1;
            r_hi_cnt   <= '0;
          end
        end
        StBurst: begin
          if (r_cnt == CNT_W'(BURST_CYC - 1)) begin
            r_state <= StEcho;
            r_echo  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StEcho: begin
          if (r_cnt == w_echo_last) begin
            r_state <= StHoldoff;
            r_echo  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StHoldoff: begin
          if (r_cnt == CNT_W'(HOLD_CYC - 1)) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= StIdle;
          r_echo  <= 1'b0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_echo     = r_echo;
  assign o_busy     = r_busy;
  assign o_trig_err = r_trig_err;

endmodule

// File: tb/tb_hcsr04_sensor_model.sv
// Bench for hcsr04_sensor_model with scaled-down timing; expectations come from event-time
// arithmetic on the trigger/echo protocol rules.
`timescale 1ns/1ps
module tb_hcsr04_sensor_model;

  localparam int unsigned T_CLK       = 250;
  localparam int unsigned TRIG_MIN_US = 3;
  localparam int unsigned T_BURST_US  = 5;
  localparam int unsigned ECHO_MAX_US = 40;
  localparam int unsigned HOLDOFF_US  = 10;
  localparam int unsigned CYC         = 1000 / T_CLK;
  localparam int unsigned TRIG_CYC    = TRIG_MIN_US * CYC;
  localparam int unsigned BURST_CYC   = T_BURST_US * CYC;
  localparam int unsigned HOLD_CYC    = HOLDOFF_US * CYC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0;
  logic [15:0] echo_us = 16'd0;
  logic        echo, busy, trig_err;

  int errors = 0;
  int checks = 0;

  hcsr04_sensor_model #(
    .T_CLK      (T_CLK),
    .TRIG_MIN_US(TRIG_MIN_US),
    .T_BURST_US (T_BURST_US),
    .ECHO_MAX_US(ECHO_MAX_US),
    .HOLDOFF_US (HOLDOFF_US)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_trigger (trig),
    .i_echo_us (echo_us),
    .o_echo    (echo),
    .o_busy    (busy),
    .o_trig_err(trig_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: edge times are recorded as the posedge count seen at the following negedge.
  logic        m_prev_echo = 1'b0;
  logic        m_prev_busy = 1'b0;
  int unsigned rise_cnt = 0, rise_cyc = 0, fall_cyc = 0;
  int unsigned err_cnt = 0, err_cyc = 0, busy_fall_cyc = 0;
  always @(negedge clk) begin
    m_prev_echo <= echo;
    m_prev_busy <= busy;
    if (echo === 1'b1 && m_prev_echo === 1'b0) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (echo === 1'b0 && m_prev_echo === 1'b1) fall_cyc <= cyc;
    if (busy === 1'b0 && m_prev_busy === 1'b1) busy_fall_cyc <= cyc;
    if (trig_err === 1'b1) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
  end

  function automatic int unsigned exp_width_us(input int unsigned us);
    if (us == 0 || us > ECHO_MAX_US) return ECHO_MAX_US;
    return us;
  endfunction

  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(posedge clk);
    #1;
  endtask

  // n cycles of trigger high; t0 is the first edge that samples it low.
  task automatic pulse(input int unsigned n, output int unsigned t0);
    @(posedge clk);
    #1;
    trig = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    trig = 1'b0;
    t0 = cyc + 1;
  endtask

  // One full valid transaction; returns the predicted echo fall time.
  task automatic valid_trial(input int unsigned n, input int unsigned us, input string tag,
                             output int unsigned exp_fall);
    int unsigned t0, r0, e0, exp_rise;
    r0 = rise_cnt;
    e0 = err_cnt;
    echo_us = 16'(us);
    pulse(n, t0);
    exp_rise = t0 + BURST_CYC;
    exp_fall = exp_rise + exp_width_us(us) * CYC;
    wait_until(t0 + 2);
    echo_us = 16'($urandom_range(0, 65535));
    wait_until(exp_fall + HOLD_CYC + 2);
    checks++;
    if (rise_cnt !== r0 + 1) begin
      errors++;
      $display("FAIL %s rise_count: got %0d expected %0d", tag, rise_cnt - r0, 1);
    end
    checks++;
    if (rise_cyc !== exp_rise) begin
      errors++;
      $display("FAIL %s rise_time: got %0d expected %0d", tag, rise_cyc, exp_rise);
    end
    checks++;
    if (fall_cyc - rise_cyc !== exp_width_us(us) * CYC) begin
      errors++;
      $display("FAIL %s echo_width: got %0d expected %0d", tag, fall_cyc - rise_cyc,
               exp_width_us(us) * CYC);
    end
    checks++;
    if (err_cnt !== e0) begin
      errors++;
      $display("FAIL %s trig_err: got %0d expected %0d", tag, err_cnt - e0, 0);
    end
    checks++;
    if (busy_fall_cyc !== exp_fall + HOLD_CYC) begin
      errors++;
      $display("FAIL %s busy_fall: got %0d expected %0d", tag, busy_fall_cyc,
               exp_fall + HOLD_CYC);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (echo !== 1'b0) begin errors++; $display("FAIL reset_echo: got %b expected 0", echo); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (trig_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_trig_err: got %b expected 0", trig_err);
    end
  endtask

  task automatic test_valid();
    int unsigned f;
    valid_trial(TRIG_CYC, 25, "valid_min_width", f);
    valid_trial(TRIG_CYC + 60, 7, "valid_long_hold", f);
    for (int i = 0; i < 6; i++) begin
      valid_trial($urandom_range(TRIG_CYC, TRIG_CYC + 20), $urandom_range(1, ECHO_MAX_US),
                  "valid_rand", f);
    end
  endtask

  task automatic test_clamp();
    int unsigned f;
    valid_trial(TRIG_CYC + 2, 0, "clamp_zero", f);
    valid_trial(TRIG_CYC + 2, ECHO_MAX_US + 1, "clamp_over", f);
    valid_trial(TRIG_CYC + 2, 65535, "clamp_max16", f);
    valid_trial(TRIG_CYC + 2, ECHO_MAX_US, "clamp_edge", f);
    valid_trial(TRIG_CYC + 2, 1, "clamp_one", f);
  endtask

  task automatic test_short();
    int unsigned n, t0, r0, e0;
    for (int i = 0; i < 4; i++) begin
      n = (i == 0) ? TRIG_CYC - 1 : (i == 1) ? 1 : $urandom_range(1, TRIG_CYC - 1);
      r0 = rise_cnt;
      e0 = err_cnt;
      echo_us = 16'($urandom_range(1, ECHO_MAX_US));
      pulse(n, t0);
      wait_until(t0 + BURST_CYC + 10);
      checks++;
      if (err_cnt !== e0 + 1) begin
        errors++;
        $display("FAIL short_err_cycles n=%0d: got %0d expected %0d", n, err_cnt - e0, 1);
      end
      checks++;
      if (err_cyc !== t0) begin
        errors++;
        $display("FAIL short_err_time n=%0d: got %0d expected %0d", n, err_cyc, t0);
      end
      checks++;
      if (busy_fall_cyc !== t0) begin
        errors++;
        $display("FAIL short_busy_fall n=%0d: got %0d expected %0d", n, busy_fall_cyc, t0);
      end
      checks++;
      if (rise_cnt !== r0) begin
        errors++;
        $display("FAIL short_no_echo n=%0d: got %0d expected %0d", n, rise_cnt - r0, 0);
      end
    end
  endtask

  task automatic test_holdoff();
    int unsigned f, t0, r0, e0;
    valid_trial(TRIG_CYC + 1, 5, "holdoff_first", f);
    // Rerun the timing by hand so a pulse can be placed inside the holdoff window.
    echo_us = 16'd5;
    pulse(TRIG_CYC + 1, t0);
    f = t0 + BURST_CYC + 5 * CYC;
    wait_until(f + 5);
    r0 = rise_cnt;
    e0 = err_cnt;
    pulse(TRIG_CYC + 3, t0);
    wait_until(f + HOLD_CYC + BURST_CYC + 8 * CYC);
    checks++;
    if (rise_cnt !== r0 + 0 || err_cnt !== e0) begin
      errors++;
      $display("FAIL holdoff_ignored: got rises=%0d errs=%0d expected 0 0", rise_cnt - r0,
               err_cnt - e0);
    end
    valid_trial(TRIG_CYC + 4, 9, "holdoff_after", f);
    // Trigger already high when holdoff ends: width counts from idle entry only.
    echo_us = 16'd3;
    pulse(TRIG_CYC, t0);
    f = t0 + BURST_CYC + 3 * CYC;
    wait_until(f + HOLD_CYC - 5);
    r0 = rise_cnt;
    e0 = err_cnt;
    trig = 1'b1;
    wait_until(f + HOLD_CYC + 5);
    trig = 1'b0;
    t0 = cyc + 1;
    wait_until(t0 + BURST_CYC + 10);
    checks++;
    if (err_cyc !== t0 || err_cnt !== e0 + 1) begin
      errors++;
      $display("FAIL holdoff_carry_err: got time=%0d count=%0d expected time=%0d count=1",
               err_cyc, err_cnt - e0, t0);
    end
    checks++;
    if (rise_cnt !== r0) begin
      errors++;
      $display("FAIL holdoff_carry_no_echo: got %0d expected 0", rise_cnt - r0);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned t0, f;
    echo_us = 16'd30;
    pulse(TRIG_CYC + 2, t0);
    wait_until(t0 + BURST_CYC + 50);
    @(negedge clk);
    checks++;
    if (echo !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre_echo: got %b expected 1", echo);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (echo !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abort: got echo=%b busy=%b expected 0 0", echo, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    valid_trial(TRIG_CYC + 5, 17, "reset_mid_after", f);
  endtask

  initial begin
    test_reset();
    test_valid();
    test_clamp();
    test_short();
    test_holdoff();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
